// File: rtl/regfile_dump_reader.sv
// Walks a register-set address window through one read port and streams each
// (addr, data) pair out on a valid/ready channel, pulsing done after the last beat.
module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_first_addr,
  input  logic [ADDR_WIDTH-1:0] i_last_addr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic [ADDR_WIDTH-1:0] ptr_next;

  assign ptr_next = ptr + AddrOne;

  // o_rd_addr is registered so it equals ptr exactly during READ and 0 otherwise.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= StIdle;
      ptr       <= '0;
      end_addr  <= '0;
      o_rd_addr <= '0;
      o_addr    <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (i_start) begin
            ptr       <= i_first_addr;
            end_addr  <= i_last_addr;
            o_rd_addr <= i_first_addr;
            o_busy    <= 1'b1;
            state     <= StRead;
          end
        end
        StRead: begin
          o_data    <= i_rd_data;
          o_addr    <= ptr;
          o_last    <= (ptr == end_addr);
          o_valid   <= 1'b1;
          o_rd_addr <= '0;
          state     <= StSend;
        end
        StSend: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (o_last) begin
              o_done <= 1'b1;
              state  <= StDone;
            end else begin
              ptr       <= ptr_next;
              o_rd_addr <= ptr_next;
              state     <= StRead;
            end
          end
        end
        StDone: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed table-driven bench for regfile_dump_reader with a behavioural 32x32
// register set (x0 reads as 0, writes land after the read at the same edge).
module tb_regfile_dump_reader;

  localparam logic [4:0]  WrAddr = 5'd7;
  localparam logic [31:0] WrData = 32'hCAFEF00D;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [4:0]  i_first_addr = '0;
  logic [4:0]  i_last_addr = '0;
  logic [4:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [4:0]  o_addr;
  logic [31:0] o_data;
  logic        o_last;
  logic        o_busy;
  logic        o_done;

  logic [31:0] regs [32];
  logic [31:0] gold [32];
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    logic [4:0]  first;
    logic [4:0]  last;
    int          mode;       // 0: ready tied high, 1: one low cycle in every four
    bit          restart;    // hold i_start high while o_valid
    bit          arm_write;  // write WrAddr in the same cycle it is read
    bit          pre_en;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    int          exp_k;
  } vec_t;

  vec_t vecs [6];

  regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_first_addr (i_first_addr),
    .i_last_addr  (i_last_addr),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  assign i_rd_data = (o_rd_addr == 5'd0) ? 32'd0 : regs[o_rd_addr];

  always @(posedge i_clk) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, o_done}, 32'd0);
    check({tag, "_last"}, {31'd0, o_last}, 32'd0);
    check({tag, "_addr"}, {27'd0, o_addr}, 32'd0);
    check({tag, "_data"}, o_data, 32'd0);
    check({tag, "_rd_addr"}, {27'd0, o_rd_addr}, 32'd0);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge i_clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge i_clk);
    wr_en = 1'b0;
  endtask

  task automatic run_window(input vec_t v);
    int         beat = 0;
    int         done_cnt = 0;
    int         off = 1;
    bit         stall = 1'b0;
    bit         first_seen = 1'b0;
    bit         finished = 1'b0;
    logic [4:0] s_addr = '0;
    logic [31:0] s_data = '0;
    logic       s_last = 1'b0;
    logic [4:0] ea;

    @(negedge i_clk);
    i_first_addr = v.first;
    i_last_addr = v.last;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    // Scramble the window inputs; they must not be re-sampled mid-dump.
    i_first_addr = v.first + 5'd9;
    i_last_addr = v.first + 5'd9;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);

    while (!finished && off < 400) begin
      i_ready = (v.mode == 0) ? 1'b1 : ((off % 4) != 0);
      i_start = v.restart && o_valid;
      wr_en = v.arm_write && o_busy && (o_rd_addr == WrAddr);
      wr_addr = WrAddr;
      wr_data = WrData;
      if (o_valid) begin
        if (!first_seen && v.mode == 0) check("first_valid_cycle", off, 32'd2);
        first_seen = 1'b1;
        if (stall) begin
          check("stall_addr", {27'd0, o_addr}, {27'd0, s_addr});
          check("stall_data", o_data, s_data);
          check("stall_last", {31'd0, o_last}, {31'd0, s_last});
        end
        if (i_ready) begin
          ea = v.first + 5'(beat);
          check("beat_addr", {27'd0, o_addr}, {27'd0, ea});
          check("beat_data", o_data, gold[ea]);
          check("beat_last", {31'd0, o_last}, {31'd0, (beat == v.exp_k - 1)});
          beat++;
        end
        stall = !i_ready;
        s_addr = o_addr;
        s_data = o_data;
        s_last = o_last;
      end else if (stall) begin
        check("valid_dropped", 32'd0, 32'd1);
        stall = 1'b0;
      end
      if (o_done) begin
        done_cnt++;
        check("done_beats", beat, v.exp_k);
        if (v.mode == 0) check("done_cycle", off, 2 * v.exp_k + 1);
      end else if (done_cnt > 0) begin
        finished = 1'b1;
      end
      @(negedge i_clk);
      off++;
    end
    i_start = 1'b0;
    wr_en = 1'b0;
    i_ready = 1'b0;
    check("window_finished", {31'd0, finished}, 32'd1);
    check("done_pulses", done_cnt, 32'd1);
    check("busy_after_done", {31'd0, o_busy}, 32'd0);
    check("valid_after_done", {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    int   waits;

    vecs[0] = '{first: 5'd0,  last: 5'd31, mode: 0, restart: 0, arm_write: 0,
                pre_en: 0, pre_addr: 5'd0, pre_data: 32'd0, exp_k: 32};
    vecs[1] = '{first: 5'd0,  last: 5'd31, mode: 1, restart: 0, arm_write: 0,
                pre_en: 0, pre_addr: 5'd0, pre_data: 32'd0, exp_k: 32};
    vecs[2] = '{first: 5'd30, last: 5'd1,  mode: 0, restart: 0, arm_write: 0,
                pre_en: 0, pre_addr: 5'd0, pre_data: 32'd0, exp_k: 4};
    vecs[3] = '{first: 5'd5,  last: 5'd5,  mode: 0, restart: 1, arm_write: 0,
                pre_en: 1, pre_addr: 5'd5, pre_data: 32'hDEADBEEF, exp_k: 1};
    vecs[4] = '{first: 5'd7,  last: 5'd7,  mode: 0, restart: 0, arm_write: 1,
                pre_en: 0, pre_addr: 5'd0, pre_data: 32'd0, exp_k: 1};
    vecs[5] = '{first: 5'd6,  last: 5'd8,  mode: 1, restart: 0, arm_write: 0,
                pre_en: 0, pre_addr: 5'd0, pre_data: 32'd0, exp_k: 3};

    #3 i_rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;

    gold[0] = 32'd0;
    for (int n = 1; n < 32; n++) begin
      gold[n] = 32'(n) * 32'h11111111;
      write_reg(5'(n), gold[n]);
    end

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_en) begin
        write_reg(vecs[i].pre_addr, vecs[i].pre_data);
        gold[vecs[i].pre_addr] = vecs[i].pre_data;
      end
      run_window(vecs[i]);
      if (vecs[i].arm_write) gold[WrAddr] = WrData;
      repeat (2) @(negedge i_clk);
      check("idle_after_vec", {31'd0, o_busy}, 32'd0);
    end

    // Reset in the middle of a stalled SEND must clear everything at once.
    @(negedge i_clk);
    i_first_addr = 5'd0;
    i_last_addr = 5'd31;
    i_start = 1'b1;
    i_ready = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    waits = 0;
    while (!o_valid && waits < 10) begin
      @(negedge i_clk);
      waits++;
    end
    check("mid_send_valid", {31'd0, o_valid}, 32'd1);
    i_rst = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) begin
      @(negedge i_clk);
      check("no_done_in_reset", {31'd0, o_done}, 32'd0);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    check("idle_after_release", {31'd0, o_busy}, 32'd0);

    rv = '{first: 5'd3, last: 5'd4, mode: 0, restart: 0, arm_write: 0,
           pre_en: 0, pre_addr: 5'd0, pre_data: 32'd0, exp_k: 2};
    run_window(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
